// File: rtl/muldiv_seq_if.sv
// muldiv_seq_if: start/operand request and busy/done/result response bundle
// for the sequential multiply/divide unit. The CPU control side uses the
// master modport; the unit itself uses the slave modport.
interface muldiv_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             div_by_zero;

  modport master (
    output start, op, a, b,
    input  busy, done, hi, lo, div_by_zero
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, hi, lo, div_by_zero
  );
endinterface

// File: rtl/muldiv_seq.sv
// muldiv_seq: sequential 32-bit MULT/MULTU/DIV/DIVU unit.
// Signed operations are reduced to magnitudes in PREP. RUN then performs
// 32 radix-2 steps: shift-add for multiply, restoring for divide. FIX
// restores the signs and writes HI/LO.
// Define MULDIV_DIV_EN to build the divide datapath. Without it, divide
// opcodes complete after one busy cycle and leave HI/LO untouched.
module muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic        clk,
  input  logic        reset,
  muldiv_seq_if.slave bus
);

  typedef enum logic [1:0] {IDLE, PREP, RUN, FIX} state_t;

  state_t             state;
  logic [4:0]         count;
  logic [1:0]         op_r;
  logic [WIDTH-1:0]   a_r;
  logic [WIDTH-1:0]   b_r;
  logic [WIDTH-1:0]   mag_b;
  // Upper half: partial product / partial remainder.
  // Lower half: multiplier bits / dividend-then-quotient bits.
  logic [2*WIDTH-1:0] acc;
  logic               neg_lo;
`ifdef MULDIV_DIV_EN
  logic               neg_hi;
`endif
  logic               busy_r;
  logic               done_r;
  logic               dbz_r;
  logic [WIDTH-1:0]   hi_r;
  logic [WIDTH-1:0]   lo_r;

  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [2*WIDTH-1:0] prod_fix;

  // Widen to WIDTH+1 bits so that negating 0x80000000 yields the correct
  // unsigned magnitude.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                 input logic is_signed);
    logic [WIDTH:0] ext;
    ext = {is_signed & v[WIDTH-1], v};
    if (ext[WIDTH]) ext = -ext;
    return ext[WIDTH-1:0];
  endfunction

  // One shift-add multiply step, plus the sign-corrected final product.
  always_comb begin
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mag_b} : '0);
    mul_next = {mul_sum, acc[WIDTH-1:1]};
    prod_fix = neg_lo ? -acc : acc;
  end

`ifdef MULDIV_DIV_EN
  logic [WIDTH:0]     div_shift;
  logic [WIDTH+1:0]   div_diff;
  logic [2*WIDTH-1:0] div_next;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;
  logic               unused_div_bit;

  // One restoring-divide step, plus the independently sign-corrected
  // quotient and remainder.
  always_comb begin
    div_shift      = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    div_diff       = {1'b0, div_shift} - {2'b00, mag_b};
    unused_div_bit = div_diff[WIDTH];
    if (!div_diff[WIDTH+1])
      div_next = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    else
      div_next = {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    quo_fix = neg_lo ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem_fix = neg_hi ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  end
`endif

  // Control FSM and datapath registers. All outputs are registered, and
  // HI/LO change only on the FIX cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      count  <= 5'd0;
      op_r   <= 2'b00;
      a_r    <= '0;
      b_r    <= '0;
      mag_b  <= '0;
      acc    <= '0;
      neg_lo <= 1'b0;
`ifdef MULDIV_DIV_EN
      neg_hi <= 1'b0;
`endif
      busy_r <= 1'b0;
      done_r <= 1'b0;
      dbz_r  <= 1'b0;
      hi_r   <= '0;
      lo_r   <= '0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            op_r   <= bus.op;
            a_r    <= bus.a;
            b_r    <= bus.b;
            dbz_r  <= 1'b0;
            busy_r <= 1'b1;
`ifdef MULDIV_DIV_EN
            state  <= PREP;
`else
            state  <= bus.op[1] ? FIX : PREP;
`endif
          end
        end
        PREP: begin
          mag_b  <= magnitude(b_r, op_r[0]);
          acc    <= {{WIDTH{1'b0}}, magnitude(a_r, op_r[0])};
          neg_lo <= op_r[0] & (a_r[WIDTH-1] ^ b_r[WIDTH-1]);
`ifdef MULDIV_DIV_EN
          neg_hi <= op_r[0] & a_r[WIDTH-1];
`endif
          count  <= 5'd31;
          state  <= RUN;
        end
        RUN: begin
`ifdef MULDIV_DIV_EN
          acc <= op_r[1] ? div_next : mul_next;
`else
          acc <= mul_next;
`endif
          count <= count - 5'd1;
          if (count == 5'd0) state <= FIX;
        end
        FIX: begin
          busy_r <= 1'b0;
          done_r <= 1'b1;
          state  <= IDLE;
`ifdef MULDIV_DIV_EN
          if (op_r[1]) begin
            if (b_r == '0) begin
              lo_r  <= '1;
              hi_r  <= a_r;
              dbz_r <= 1'b1;
            end else begin
              lo_r <= quo_fix;
              hi_r <= rem_fix;
            end
          end else begin
            hi_r <= prod_fix[2*WIDTH-1:WIDTH];
            lo_r <= prod_fix[WIDTH-1:0];
          end
`else
          if (!op_r[1]) begin
            hi_r <= prod_fix[2*WIDTH-1:WIDTH];
            lo_r <= prod_fix[WIDTH-1:0];
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy        = busy_r;
  assign bus.done        = done_r;
  assign bus.hi          = hi_r;
  assign bus.lo          = lo_r;
  assign bus.div_by_zero = dbz_r;

endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: directed test of muldiv_seq against an arithmetic reference
// model. The model predicts busy/done/hi/lo/div_by_zero from the operation
// latency and plain SystemVerilog arithmetic. Divide expectations follow
// MULDIV_DIV_EN in the same way the design does.
module tb_muldiv_seq;

  logic clk = 1'b0;
  logic reset;
  int   total;
  int   passed;

  logic        m_busy;
  logic        m_done;
  logic        m_dbz;
  logic [31:0] m_hi;
  logic [31:0] m_lo;
  int          m_left;
  logic        p_write;
  logic [31:0] p_hi;
  logic [31:0] p_lo;
  logic        p_dbz;

  muldiv_seq_if bus ();

  muldiv_seq dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act,
                             input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t",
                  name, act, exp, $time);
  endtask

  task automatic checkResult(input string name, input logic [31:0] exp_hi,
                             input logic [31:0] exp_lo, input logic exp_dbz);
    checkOutput({name, "_hi"}, 64'(bus.hi), 64'(exp_hi));
    checkOutput({name, "_lo"}, 64'(bus.lo), 64'(exp_lo));
    checkOutput({name, "_dbz"}, 64'(bus.div_by_zero), 64'(exp_dbz));
  endtask

  // Reference arithmetic: result, whether HI/LO are written, and latency.
  function automatic void modelResult(input logic [1:0] op,
                                      input logic [31:0] av, bv,
                                      output logic wr,
                                      output logic [31:0] rh, rl,
                                      output logic dz, output int lat);
    logic [63:0] p;
    longint      sa;
    longint      sb;
`ifdef MULDIV_DIV_EN
    longint      q;
    longint      r;
`endif
    sa  = longint'($signed(av));
    sb  = longint'($signed(bv));
    wr  = 1'b1;
    dz  = 1'b0;
    lat = 34;
    rh  = '0;
    rl  = '0;
    p   = '0;
    case (op)
      2'b00: begin
        p  = {32'b0, av} * {32'b0, bv};
        rh = p[63:32];
        rl = p[31:0];
      end
      2'b01: begin
        p  = sa * sb;
        rh = p[63:32];
        rl = p[31:0];
      end
      default: begin
`ifdef MULDIV_DIV_EN
        if (bv == 32'd0) begin
          rl = 32'hFFFFFFFF;
          rh = av;
          dz = 1'b1;
        end else if (op == 2'b10) begin
          rl = av / bv;
          rh = av % bv;
        end else begin
          q  = sa / sb;
          r  = sa % sb;
          p  = q;
          rl = p[31:0];
          p  = r;
          rh = p[31:0];
        end
`else
        wr  = 1'b0;
        lat = 1;
`endif
      end
    endcase
  endfunction

  // Reference timing: a request accepted while idle completes lat edges later.
  initial forever begin
    @(posedge clk or posedge reset);
    if (reset) begin
      m_busy = 1'b0;
      m_done = 1'b0;
      m_dbz  = 1'b0;
      m_hi   = '0;
      m_lo   = '0;
      m_left = 0;
    end else begin
      m_done = 1'b0;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_busy = 1'b0;
          m_done = 1'b1;
          if (p_write) begin
            m_hi  = p_hi;
            m_lo  = p_lo;
            m_dbz = p_dbz;
          end
        end
      end else if (bus.start) begin
        modelResult(bus.op, bus.a, bus.b, p_write, p_hi, p_lo, p_dbz, m_left);
        m_busy = 1'b1;
        m_dbz  = 1'b0;
      end
    end
  end

  // Cycle-by-cycle comparison of every output against the model.
  initial forever begin
    @(negedge clk);
    checkOutput("cyc_busy", 64'(bus.busy), 64'(m_busy));
    checkOutput("cyc_done", 64'(bus.done), 64'(m_done));
    checkOutput("cyc_hi", 64'(bus.hi), 64'(m_hi));
    checkOutput("cyc_lo", 64'(bus.lo), 64'(m_lo));
    checkOutput("cyc_dbz", 64'(bus.div_by_zero), 64'(m_dbz));
  end

  // Drive a one-cycle start pulse; returns just after the sampling edge.
  task automatic applyStimulus(input logic [1:0] o, input logic [31:0] av,
                               input logic [31:0] bv);
    bus.start = 1'b1;
    bus.op    = o;
    bus.a     = av;
    bus.b     = bv;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  // Count edges until done is seen, bounded, noting any cycle with busy low.
  task automatic waitDone(input int offset, output int n, output int gaps);
    n    = offset;
    gaps = 0;
    while (!bus.done && n < 200) begin
      if (!bus.busy) gaps++;
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, total=%0d", total);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    int gaps;
    int dones;
    int div_lat;
    total     = 0;
    passed    = 0;
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.op    = 2'b00;
    bus.a     = '0;
    bus.b     = '0;
`ifdef MULDIV_DIV_EN
    div_lat = 34;
`else
    div_lat = 1;
`endif
    #12;
    checkOutput("reset_busy", 64'(bus.busy), 64'd0);
    checkOutput("reset_done", 64'(bus.done), 64'd0);
    checkResult("reset", 32'h0, 32'h0, 1'b0);
    #10 reset = 1'b0;
    @(negedge clk);

    applyStimulus(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF);
    waitDone(0, n, gaps);
    checkOutput("multu_latency", 64'(n), 64'd34);
    checkOutput("multu_busy_gaps", 64'(gaps), 64'd0);
    checkResult("multu_max", 32'hFFFFFFFE, 32'h00000001, 1'b0);

    applyStimulus(2'b01, 32'hFFFFFFFD, 32'd5);
    waitDone(0, n, gaps);
    checkOutput("mult_latency", 64'(n), 64'd34);
    checkResult("mult_neg", 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0);

    applyStimulus(2'b11, 32'hFFFFFFF9, 32'd2);
    waitDone(0, n, gaps);
    checkOutput("div_latency", 64'(n), 64'(div_lat));
`ifdef MULDIV_DIV_EN
    checkResult("div_neg", 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
`else
    checkResult("div_disabled", 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0);
`endif

    applyStimulus(2'b10, 32'd100, 32'd0);
    waitDone(0, n, gaps);
    checkOutput("divu_zero_latency", 64'(n), 64'(div_lat));
`ifdef MULDIV_DIV_EN
    checkResult("divu_zero", 32'h00000064, 32'hFFFFFFFF, 1'b1);
`else
    checkResult("divu_zero_disabled", 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0);
`endif

    applyStimulus(2'b10, 32'd100, 32'd7);
    waitDone(0, n, gaps);
`ifdef MULDIV_DIV_EN
    checkResult("divu_100_7", 32'd2, 32'd14, 1'b0);
`else
    checkResult("divu_disabled", 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0);
`endif

    applyStimulus(2'b11, 32'h80000000, 32'hFFFFFFFF);
    waitDone(0, n, gaps);
`ifdef MULDIV_DIV_EN
    checkResult("div_overflow", 32'h0, 32'h80000000, 1'b0);
`else
    checkResult("div_ovf_disabled", 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0);
`endif

    applyStimulus(2'b00, 32'd3, 32'd4);
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    applyStimulus(2'b00, 32'd7, 32'd9);
    waitDone(10, n, gaps);
    checkOutput("busy_start_latency", 64'(n), 64'd34);
    checkResult("busy_start", 32'h0, 32'd12, 1'b0);
    dones = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus.done) dones++;
    end
    checkOutput("no_queued_op", 64'(dones), 64'd0);
    checkResult("busy_hold", 32'h0, 32'd12, 1'b0);

    applyStimulus(2'b00, 32'd2, 32'd3);
    waitDone(0, n, gaps);
    checkResult("b2b_first", 32'h0, 32'd6, 1'b0);
    applyStimulus(2'b00, 32'd6, 32'd7);
    waitDone(0, n, gaps);
    checkOutput("b2b_latency", 64'(n), 64'd34);
    checkResult("b2b_second", 32'h0, 32'd42, 1'b0);

    applyStimulus(2'b00, 32'd5, 32'd5);
    repeat (19) begin
      @(posedge clk);
      #1;
    end
    #2 reset = 1'b1;
    #1;
    checkOutput("abort_busy", 64'(bus.busy), 64'd0);
    checkOutput("abort_done", 64'(bus.done), 64'd0);
    checkResult("abort", 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    #2 reset = 1'b0;
    dones = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus.done) dones++;
    end
    checkOutput("abort_no_done", 64'(dones), 64'd0);

    applyStimulus(2'b00, 32'h12345678, 32'h00000010);
    waitDone(0, n, gaps);
    checkResult("multu_shift", 32'h00000001, 32'h23456780, 1'b0);
    applyStimulus(2'b01, 32'hFFFFFFFF, 32'h80000000);
    waitDone(0, n, gaps);
    checkOutput("mult_min_latency", 64'(n), 64'd34);
    checkResult("mult_min", 32'h0, 32'h80000000, 1'b0);

    @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
